// File: rtl/ascon_fsm_param.sv
// Ascon AEAD control FSM: sequences init, AD absorption, PT/CT processing and
// finalisation for a state-register/permutation datapath with variable block counts.
module ascon_fsm_param #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int NB_W     = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [NB_W-1:0] nb_ad_i,
  input  logic [NB_W-1:0] nb_pt_i,
  input  logic            decrypt_i,
  input  logic            data_valid_i,
  output logic            busy_o,
  output logic            input_select_o,
  output logic            ena_reg_state_o,
  output logic            ena_round_o,
  output logic            ena_xor_up_o,
  output logic            replace_o,
  output logic            ena_xor_down_o,
  output logic [1:0]      conf_xor_down_o,
  output logic [3:0]      round_o,
  output logic [NB_W-1:0] block_idx_o,
  output logic            cipher_valid_o,
  output logic            end_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_INIT     = 4'd2;
  localparam logic [3:0] S_INIT_END = 4'd3;
  localparam logic [3:0] S_AD_WAIT  = 4'd4;
  localparam logic [3:0] S_AD_PERM  = 4'd5;
  localparam logic [3:0] S_DSEP     = 4'd6;
  localparam logic [3:0] S_PT_WAIT  = 4'd7;
  localparam logic [3:0] S_PT_PERM  = 4'd8;
  localparam logic [3:0] S_FINAL    = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  localparam logic [3:0]      FIRST_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0]      FIRST_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0]      LAST_RC = 4'd11;
  localparam logic [NB_W-1:0] ONE     = NB_W'(1);

  logic [3:0]      state;
  logic [NB_W-1:0] nb_ad_q;
  logic [NB_W-1:0] nb_pt_q;
  logic            decrypt_q;
  logic            ad_last;
  logic            pt_last;

  // nb_pt_q already has 0 promoted to 1, so the last-block test needs no special case
  assign ad_last = (block_idx_o == nb_ad_q - ONE);
  assign pt_last = (block_idx_o == nb_pt_q - ONE);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      round_o     <= '0;
      block_idx_o <= '0;
      nb_ad_q     <= '0;
      nb_pt_q     <= '0;
      decrypt_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            nb_ad_q   <= nb_ad_i;
            nb_pt_q   <= (nb_pt_i == '0) ? ONE : nb_pt_i;
            decrypt_q <= decrypt_i;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          round_o <= FIRST_A;
          state   <= S_INIT;
        end
        S_INIT: begin
          round_o <= round_o + 4'd1;
          if (round_o == LAST_RC) state <= S_INIT_END;
        end
        S_INIT_END: begin
          block_idx_o <= '0;
          round_o     <= FIRST_B;
          state       <= (nb_ad_q == '0) ? S_DSEP : S_AD_WAIT;
        end
        S_AD_WAIT: begin
          if (data_valid_i) begin
            round_o <= round_o + 4'd1;
            state   <= S_AD_PERM;
          end
        end
        S_AD_PERM: begin
          if (round_o == LAST_RC) begin
            round_o     <= FIRST_B;
            block_idx_o <= block_idx_o + ONE;
            state       <= ad_last ? S_DSEP : S_AD_WAIT;
          end else begin
            round_o <= round_o + 4'd1;
          end
        end
        S_DSEP: begin
          block_idx_o <= '0;
          round_o     <= FIRST_B;
          state       <= S_PT_WAIT;
        end
        S_PT_WAIT: begin
          if (data_valid_i) begin
            if (pt_last) begin
              round_o <= FIRST_A;
              state   <= S_FINAL;
            end else begin
              round_o <= round_o + 4'd1;
              state   <= S_PT_PERM;
            end
          end
        end
        S_PT_PERM: begin
          if (round_o == LAST_RC) begin
            round_o     <= FIRST_B;
            block_idx_o <= block_idx_o + ONE;
            state       <= S_PT_WAIT;
          end else begin
            round_o <= round_o + 4'd1;
          end
        end
        S_FINAL: begin
          round_o <= round_o + 4'd1;
          if (round_o == LAST_RC) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o          = (state != S_IDLE);
    input_select_o  = 1'b0;
    ena_reg_state_o = 1'b0;
    ena_round_o     = 1'b0;
    ena_xor_up_o    = 1'b0;
    replace_o       = 1'b0;
    ena_xor_down_o  = 1'b0;
    conf_xor_down_o = 2'b00;
    cipher_valid_o  = 1'b0;
    end_o           = 1'b0;
    case (state)
      S_LOAD: begin
        input_select_o  = 1'b1;
        ena_reg_state_o = 1'b1;
      end
      S_INIT, S_AD_PERM, S_PT_PERM: begin
        ena_reg_state_o = 1'b1;
        ena_round_o     = 1'b1;
      end
      S_INIT_END: begin
        ena_reg_state_o = 1'b1;
        ena_xor_down_o  = 1'b1;
        conf_xor_down_o = 2'b00;
      end
      S_AD_WAIT: begin
        ena_reg_state_o = data_valid_i;
        ena_xor_up_o    = data_valid_i;
        ena_round_o     = data_valid_i;
      end
      S_DSEP: begin
        ena_reg_state_o = 1'b1;
        ena_xor_down_o  = 1'b1;
        conf_xor_down_o = 2'b01;
      end
      S_PT_WAIT: begin
        // last block skips the round and folds the key in before finalisation
        ena_reg_state_o = data_valid_i;
        ena_xor_up_o    = data_valid_i;
        cipher_valid_o  = data_valid_i;
        replace_o       = data_valid_i & decrypt_q;
        ena_round_o     = data_valid_i & ~pt_last;
        ena_xor_down_o  = data_valid_i & pt_last;
        conf_xor_down_o = pt_last ? 2'b10 : 2'b00;
      end
      S_FINAL: begin
        ena_reg_state_o = 1'b1;
        ena_round_o     = 1'b1;
        ena_xor_down_o  = (round_o == LAST_RC);
        conf_xor_down_o = 2'b11;
      end
      S_DONE: end_o = 1'b1;
      default: ;
    endcase
  end

endmodule
